// File: rtl/oam_line_scanner_pkg.sv
// Shared sprite/OAM types and constants for the PPU sprite path.
// Used by the line scanner and by the sprite fetcher.
package oam_line_scanner_pkg;

    localparam int unsigned SPRITE_Y_OFFSET      = 16;
    localparam int unsigned MAX_SPRITES_PER_LINE = 10;
    localparam int unsigned SLOT_INDEX_W         = 8;

    typedef struct packed {
        logic       bg_priority;
        logic       y_flip;
        logic       x_flip;
        logic       dmg_palette;
        logic       vram_bank;
        logic [2:0] cgb_palette;
    } sprite_flags_t;

    // One OAM entry as it appears on oam_data: {Y, X, Tile, Flags}
    typedef struct packed {
        logic [7:0]    y;
        logic [7:0]    x;
        logic [7:0]    tile;
        sprite_flags_t flags;
    } sprite_attr_t;

    typedef struct packed {
        logic [SLOT_INDEX_W-1:0] index;
        logic [7:0]              x;
        logic [7:0]              tile;
        sprite_flags_t           flags;
    } sprite_slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH
    } scan_state_e;

endpackage

// File: rtl/sprite_y_match.sv
// Vertical coverage test: does line ly fall inside a sprite's Y span.
// Unsigned 9-bit arithmetic so Y values near 255 do not wrap.
module sprite_y_match
    import oam_line_scanner_pkg::*;
(
    input  logic [7:0] ly,
    input  logic [7:0] y,
    input  logic       size16,
    output logic       hit_c
);

    logic [8:0] line_pos;
    logic [8:0] y_top;
    logic [8:0] y_end;

    assign line_pos = {1'b0, ly} + 9'(SPRITE_Y_OFFSET);
    assign y_top    = {1'b0, y};
    assign y_end    = y_top + (size16 ? 9'd16 : 9'd8);
    assign hit_c    = (line_pos >= y_top) && (line_pos < y_end);

endmodule

// File: rtl/oam_line_scanner.sv
// Mode-2 OAM search: on each line start, walks OAM and latches the first
// MAX_PER_LINE sprites covering the line into a slot list for the fetcher.
module oam_line_scanner
    import oam_line_scanner_pkg::*;
#(
    parameter int unsigned  NUM_SPRITES  = 40,
    parameter int unsigned  MAX_PER_LINE = MAX_SPRITES_PER_LINE,
    parameter bit           EARLY_EXIT   = 1'b0,
    localparam int unsigned IW           = $clog2(NUM_SPRITES),
    localparam int unsigned CW           = $clog2(MAX_PER_LINE + 1),
    localparam int unsigned SW           = $clog2(MAX_PER_LINE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          lcd_enable,
    input  logic          sprite_size,
    input  logic          start,
    input  logic [7:0]    ly,
    output logic          oam_rd,
    output logic [IW-1:0] oam_addr,
    input  logic [31:0]   oam_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    input  logic [SW-1:0] slot_sel,
    output logic [IW-1:0] slot_index,
    output logic [7:0]    slot_x,
    output logic [7:0]    slot_tile,
    output logic [7:0]    slot_flags
);

    scan_state_e   state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_q, rd_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    ly_q, ly_d;
    logic          size_q, size_d;
    logic          req_q, req_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          slot_we;

    sprite_attr_t  attr;
    sprite_slot_t  slot_d;
    sprite_slot_t  slots_q [MAX_PER_LINE];
    logic          hit_c;
    logic          full;
    logic          take;
    logic          fills;
    logic          last_req;

    assign attr = oam_data;

    sprite_y_match u_y_match (
        .ly     (ly_q),
        .y      (attr.y),
        .size16 (size_q),
        .hit_c  (hit_c)
    );

    // req_q/idx_q mark the beat whose data is on oam_data this cycle
    assign full     = (count_q == CW'(MAX_PER_LINE));
    assign take     = req_q && hit_c && !full;
    assign fills    = take && (count_q == CW'(MAX_PER_LINE - 1));
    assign last_req = (addr_q == IW'(NUM_SPRITES - 1));
    assign slot_d   = '{index: SLOT_INDEX_W'(idx_q), x: attr.x, tile: attr.tile, flags: attr.flags};

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_d    = rd_q;
        addr_d  = addr_q;
        count_d = count_q;
        ly_d    = ly_q;
        size_d  = size_q;
        req_d   = rd_q;
        idx_d   = addr_q;
        slot_we = 1'b0;

        if (take) begin
            slot_we = 1'b1;
            count_d = count_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = '0;
                    count_d = '0;
                    ly_d    = ly;
                    size_d  = sprite_size;
                end
            end
            ST_SCAN: begin
                if (last_req || (EARLY_EXIT && fills)) begin
                    state_d = ST_FLUSH;
                    rd_d    = 1'b0;
                end else begin
                    addr_d = addr_q + IW'(1);
                end
            end
            ST_FLUSH: begin
                // The final in-flight beat is compared (or discarded when full) here
                if (req_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Display off overrides everything, including a same-cycle start
        if (!lcd_enable) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            rd_d    = 1'b0;
            req_d   = 1'b0;
            count_d = '0;
            slot_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            ly_q    <= '0;
            size_q  <= 1'b0;
            req_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            ly_q    <= ly_d;
            size_q  <= size_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
                slots_q[i] <= '0;
            end
        end else if (slot_we) begin
            slots_q[count_q[SW-1:0]] <= slot_d;
        end
    end

    assign oam_rd     = rd_q;
    assign oam_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign count      = count_q;

    // 16-line sprites use an even/odd tile pair, so the fetcher sees the even tile
    assign slot_index = IW'(slots_q[slot_sel].index);
    assign slot_x     = slots_q[slot_sel].x;
    assign slot_tile  = {slots_q[slot_sel].tile[7:1], slots_q[slot_sel].tile[0] & ~size_q};
    assign slot_flags = slots_q[slot_sel].flags;

endmodule
